// File: rtl/bridge_pkg.sv
// Shared definitions for the AHB2APB bridge: APB sequencer states,
// slave memory map and AHB transfer-type encodings.
package bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_READ     = 3'd1,
        ST_WWAIT    = 3'd2,
        ST_WRITE    = 3'd3,
        ST_WRITEP   = 3'd4,
        ST_RENABLE  = 3'd5,
        ST_WENABLE  = 3'd6,
        ST_WENABLEP = 3'd7
    } apb_state_t;

    localparam logic [31:0] SLV0_BASE = 32'h8000_0000;
    localparam logic [31:0] SLV1_BASE = 32'h8400_0000;
    localparam logic [31:0] SLV2_BASE = 32'h8800_0000;
    localparam logic [31:0] SLV_END   = 32'h8BFF_FFFF;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

endpackage

// File: rtl/apb_sel_decode.sv
// Address-region to one-hot PSEL decode. Each slave owns a 64 MB window
// selected by address bits [27:26]; regions beyond NSLV select nothing.
module apb_sel_decode #(
    parameter int NSLV = 3
) (
    input  logic [1:0]      region,
    output logic [NSLV-1:0] sel
);

    // One-hot select for the region, empty for unmapped regions.
    always_comb begin
        sel = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (region == i[1:0]) begin
                sel[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_fsm_controller.sv
// APB-side sequencer of the AHB2APB bridge. Turns the pipelined AHB
// address/data into APB setup/access cycles, one transfer at a time, and
// stretches the AHB data phase with HREADYout while a write is pending.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | no APB transfer, PSEL low
// ST_READ     | read setup cycle
// ST_WWAIT    | write address captured, waiting for its data phase
// ST_WRITE    | write setup cycle, nothing queued behind it
// ST_WRITEP   | write setup cycle with another transfer pending
// ST_RENABLE  | read access cycle
// ST_WENABLE  | write access cycle, nothing queued behind it
// ST_WENABLEP | write access cycle with another transfer pending
module apb_fsm_controller
    import bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NSLV   = 3
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              valid,
    input  logic              HWRITE,
    input  logic              HWRITEreg,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [ADDR_W-1:0] HADDR_1,
    input  logic [ADDR_W-1:0] HADDR_2,
    input  logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HWDATA_1,
    output logic [NSLV-1:0]   PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    output logic              HREADYout
);

    apb_state_t        state;
    apb_state_t        state_nxt;
    logic [NSLV-1:0]   psel_nxt;
    logic              penable_nxt;
    logic              pwrite_nxt;
    logic [ADDR_W-1:0] paddr_nxt;
    logic [DATA_W-1:0] pwdata_nxt;
    logic              hready_nxt;

    logic              pipe_write;
    logic [ADDR_W-1:0] addr_src;
    logic [DATA_W-1:0] data_src;
    logic [NSLV-1:0]   sel_dec;

    // A write leaving WENABLEP belongs to the transfer two address phases
    // back; a write leaving WWAIT to the one just before; reads use HADDR.
    assign pipe_write = (state == ST_WENABLEP) && HWRITEreg;
    assign addr_src   = (state == ST_WWAIT) ? HADDR_1 :
                        pipe_write          ? HADDR_2 : HADDR;
    assign data_src   = (state == ST_WWAIT) ? HWDATA : HWDATA_1;

    apb_sel_decode #(
        .NSLV   (NSLV)
    ) u_sel_decode (
        .region (addr_src[27:26]),
        .sel    (sel_dec)
    );

    // Next state plus the registered APB/AHB outputs of the state entered.
    always_comb begin
        state_nxt   = state;
        psel_nxt    = PSEL;
        penable_nxt = PENABLE;
        pwrite_nxt  = PWRITE;
        paddr_nxt   = PADDR;
        pwdata_nxt  = PWDATA;
        hready_nxt  = HREADYout;

        case (state)
            ST_IDLE, ST_RENABLE, ST_WENABLE: begin
                if (valid && !HWRITE) begin
                    state_nxt = ST_READ;
                end else if (valid && HWRITE) begin
                    state_nxt = ST_WWAIT;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WWAIT:    state_nxt = valid ? ST_WRITEP : ST_WRITE;
            ST_READ:     state_nxt = ST_RENABLE;
            ST_WRITE:    state_nxt = valid ? ST_WENABLEP : ST_WENABLE;
            ST_WRITEP:   state_nxt = ST_WENABLEP;
            ST_WENABLEP: begin
                if (!HWRITEreg) begin
                    state_nxt = ST_READ;
                end else if (valid) begin
                    state_nxt = ST_WRITEP;
                end else begin
                    state_nxt = ST_WRITE;
                end
            end
            default:     state_nxt = ST_IDLE;
        endcase

        case (state_nxt)
            ST_READ: begin
                paddr_nxt   = addr_src;
                psel_nxt    = sel_dec;
                pwrite_nxt  = 1'b0;
                penable_nxt = 1'b0;
                hready_nxt  = 1'b0;
            end
            ST_WRITE, ST_WRITEP: begin
                paddr_nxt   = addr_src;
                pwdata_nxt  = data_src;
                psel_nxt    = sel_dec;
                pwrite_nxt  = 1'b1;
                penable_nxt = 1'b0;
                hready_nxt  = (state_nxt == ST_WRITE);
            end
            ST_RENABLE, ST_WENABLE, ST_WENABLEP: begin
                penable_nxt = 1'b1;
                hready_nxt  = (state_nxt != ST_WENABLEP);
            end
            default: begin
                // ST_IDLE and ST_WWAIT: bus idle, AHB side free to proceed
                psel_nxt    = '0;
                penable_nxt = 1'b0;
                hready_nxt  = 1'b1;
            end
        endcase
    end

    // State and output registers; reset aborts any APB cycle immediately.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= ST_IDLE;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            HREADYout <= 1'b1;
        end else begin
            state     <= state_nxt;
            PSEL      <= psel_nxt;
            PENABLE   <= penable_nxt;
            PWRITE    <= pwrite_nxt;
            PADDR     <= paddr_nxt;
            PWDATA    <= pwdata_nxt;
            HREADYout <= hready_nxt;
        end
    end

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Directed bench for apb_fsm_controller: stimulus pushes the expected
// post-edge APB outputs into a queue, monitors pop and compare.
module tb_apb_fsm_controller;

    logic        HCLK;
    logic        HRESETn;
    logic        valid;
    logic        HWRITE;
    logic        HWRITEreg;
    logic [31:0] HADDR, HADDR_1, HADDR_2;
    logic [31:0] HWDATA, HWDATA_1;
    logic [2:0]  PSEL;
    logic        PENABLE, PWRITE, HREADYout;
    logic [31:0] PADDR, PWDATA;

    typedef struct {
        int          id;
        logic [2:0]  psel;
        logic        pen;
        logic        pwr;
        logic [31:0] paddr;
        logic [31:0] pwdata;
        logic        hrdy;
    } exp_t;

    exp_t exp_q[$];
    exp_t rst_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc_id  = 0;

    apb_fsm_controller #(
        .ADDR_W (32),
        .DATA_W (32),
        .NSLV   (3)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .valid     (valid),
        .HWRITE    (HWRITE),
        .HWRITEreg (HWRITEreg),
        .HADDR     (HADDR),
        .HADDR_1   (HADDR_1),
        .HADDR_2   (HADDR_2),
        .HWDATA    (HWDATA),
        .HWDATA_1  (HWDATA_1),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .HREADYout (HREADYout)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Upstream AHB slave-interface pipeline
    initial begin
        HADDR_1 = '0; HADDR_2 = '0; HWDATA_1 = '0; HWRITEreg = 1'b0;
    end
    always @(posedge HCLK) begin
        HADDR_1   <= HADDR;
        HADDR_2   <= HADDR_1;
        HWDATA_1  <= HWDATA;
        HWRITEreg <= HWRITE;
    end

    task automatic compare(input exp_t e, input string tag);
        n_tests++;
        if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, HREADYout} !==
            {e.psel, e.pen, e.pwr, e.paddr, e.pwdata, e.hrdy}) begin
            n_fail++;
            $display("FAIL %s%0d: got psel=%b pen=%b pwr=%b paddr=%h pwdata=%h hrdy=%b, want psel=%b pen=%b pwr=%b paddr=%h pwdata=%h hrdy=%b",
                     tag, e.id, PSEL, PENABLE, PWRITE, PADDR, PWDATA, HREADYout,
                     e.psel, e.pen, e.pwr, e.paddr, e.pwdata, e.hrdy);
        end
    endtask

    // Clocked monitor: outputs settle just after each rising edge
    initial begin
        forever begin
            @(posedge HCLK);
            #2;
            if (exp_q.size() > 0) compare(exp_q.pop_front(), "cyc");
        end
    end

    // Async-reset monitor: outputs must clear without a clock edge
    initial begin
        forever begin
            @(negedge HRESETn);
            #1;
            if (rst_q.size() > 0) compare(rst_q.pop_front(), "rst");
        end
    end

    function automatic exp_t mk(input logic [2:0] ps, input logic pe, input logic pw,
                                input logic [31:0] pa, input logic [31:0] pd,
                                input logic hr);
        exp_t e;
        e.id = cyc_id; e.psel = ps; e.pen = pe; e.pwr = pw;
        e.paddr = pa; e.pwdata = pd; e.hrdy = hr;
        return e;
    endfunction

    // Drive one cycle of AHB inputs and queue the outputs after the next edge
    task automatic cyc(input logic v, input logic hw, input logic [31:0] ha,
                       input logic [31:0] hd, input logic [2:0] ps, input logic pe,
                       input logic pw, input logic [31:0] pa, input logic [31:0] pd,
                       input logic hr);
        @(negedge HCLK);
        valid = v; HWRITE = hw; HADDR = ha; HWDATA = hd;
        cyc_id++;
        exp_q.push_back(mk(ps, pe, pw, pa, pd, hr));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100000ns, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        HRESETn = 1'b0; valid = 1'b0; HWRITE = 1'b0; HADDR = '0; HWDATA = '0;

        // Reset state held across an edge
        cyc(0,0,32'h0,32'h0, 3'b000,0,0,32'h0,32'h0,1);
        @(negedge HCLK); HRESETn = 1'b1;

        // 1: single read from IDLE
        cyc(1,0,32'h8000_0010,32'h0, 3'b001,0,0,32'h8000_0010,32'h0,0);
        cyc(0,0,32'h0,32'h0,          3'b001,1,0,32'h8000_0010,32'h0,1);
        cyc(0,0,32'h0,32'h0,          3'b000,0,0,32'h8000_0010,32'h0,1);

        // 2: single write WWAIT -> WRITE -> WENABLE -> IDLE
        cyc(1,1,32'h8400_0004,32'h0,  3'b000,0,0,32'h8000_0010,32'h0,1);
        cyc(0,0,32'h0,32'hDEAD_BEEF,  3'b010,0,1,32'h8400_0004,32'hDEAD_BEEF,1);
        cyc(0,0,32'h0,32'h0,          3'b010,1,1,32'h8400_0004,32'hDEAD_BEEF,1);
        cyc(0,0,32'h0,32'h0,          3'b000,0,1,32'h8400_0004,32'hDEAD_BEEF,1);

        // 3: back-to-back reads, RENABLE chains straight to READ
        cyc(1,0,32'h8800_0000,32'h0,  3'b100,0,0,32'h8800_0000,32'hDEAD_BEEF,0);
        cyc(0,0,32'h8800_0000,32'h0,  3'b100,1,0,32'h8800_0000,32'hDEAD_BEEF,1);
        cyc(1,0,32'h8800_0004,32'h0,  3'b100,0,0,32'h8800_0004,32'hDEAD_BEEF,0);
        cyc(0,0,32'h0,32'h0,          3'b100,1,0,32'h8800_0004,32'hDEAD_BEEF,1);
        cyc(0,0,32'h0,32'h0,          3'b000,0,0,32'h8800_0004,32'hDEAD_BEEF,1);

        // 4: write then write: WWAIT -> WRITEP -> WENABLEP -> WRITE (pipelined)
        cyc(1,1,32'h8000_0020,32'h0,          3'b000,0,0,32'h8800_0004,32'hDEAD_BEEF,1);
        cyc(1,1,32'h8400_0030,32'h1111_1111,  3'b001,0,1,32'h8000_0020,32'h1111_1111,0);
        cyc(0,1,32'h8400_0030,32'h2222_2222,  3'b001,1,1,32'h8000_0020,32'h1111_1111,0);
        cyc(0,0,32'h0,32'h0,                  3'b010,0,1,32'h8400_0030,32'h2222_2222,1);
        cyc(0,0,32'h0,32'h0,                  3'b010,1,1,32'h8400_0030,32'h2222_2222,1);
        cyc(0,0,32'h0,32'h0,                  3'b000,0,1,32'h8400_0030,32'h2222_2222,1);

        // 4b: write then read: WENABLEP -> READ using HADDR
        cyc(1,1,32'h8800_0040,32'h0,          3'b000,0,1,32'h8400_0030,32'h2222_2222,1);
        cyc(1,0,32'h8000_0050,32'h3333_3333,  3'b100,0,1,32'h8800_0040,32'h3333_3333,0);
        cyc(0,0,32'h8000_0050,32'h0,          3'b100,1,1,32'h8800_0040,32'h3333_3333,0);
        cyc(0,0,32'h8000_0050,32'h0,          3'b001,0,0,32'h8000_0050,32'h3333_3333,0);
        cyc(0,0,32'h0,32'h0,                  3'b001,1,0,32'h8000_0050,32'h3333_3333,1);

        // 5: asynchronous reset in RENABLE, between clock edges
        @(posedge HCLK);
        #3;
        rst_q.push_back(mk(3'b000,0,0,32'h0,32'h0,1));
        HRESETn = 1'b0;
        @(negedge HCLK);
        HRESETn = 1'b1; valid = 1'b0;
        cyc_id++;
        exp_q.push_back(mk(3'b000,0,0,32'h0,32'h0,1));

        // 6: decode boundaries
        cyc(1,0,32'h87FF_FFFC,32'h0,  3'b010,0,0,32'h87FF_FFFC,32'h0,0);
        cyc(0,0,32'h0,32'h0,          3'b010,1,0,32'h87FF_FFFC,32'h0,1);
        cyc(1,0,32'h8BFF_FFFC,32'h0,  3'b100,0,0,32'h8BFF_FFFC,32'h0,0);
        cyc(0,0,32'h0,32'h0,          3'b100,1,0,32'h8BFF_FFFC,32'h0,1);
        cyc(1,0,32'h8400_0000,32'h0,  3'b010,0,0,32'h8400_0000,32'h0,0);
        cyc(0,0,32'h0,32'h0,          3'b010,1,0,32'h8400_0000,32'h0,1);
        cyc(0,0,32'h0,32'h0,          3'b000,0,0,32'h8400_0000,32'h0,1);

        repeat (3) @(negedge HCLK);
        n_tests++;
        if (exp_q.size() != 0 || rst_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d/%0d pending, want 0/0", exp_q.size(), rst_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
